cic_dec_ctrl: RTL and testbench
===============================

CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

Interface
REQ-001 Parameter num_of_stages, default 4: CIC stage count; sets the number of settling outputs discarded.
REQ-002 Parameter num_bits_output, default 16: width of CIC output samples.
REQ-003 Parameter div_width, default 16: width of the input-rate divider.
REQ-004 Port clk_i, input, 1: single clock for all logic.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port enable_i, input, 1: run request; 0 forces IDLE.
REQ-007 Port cfg_div_i, input, div_width: input tick period in clk cycles.
REQ-008 Port cfg_valid_i, input, 1: configuration offer.
REQ-009 Port cfg_ready_o, output, 1: configuration accept window.
REQ-010 Port tick_o, output, 1: input-rate tick to the decimator tick input.
REQ-011 Port cic_rst_o, output, 1: reset to the decimator.
REQ-012 Port tick_dec_i, input, 1: decimated tick from the decimator.
REQ-013 Port sample_i, input, num_bits_output, signed: decimator output sample.
REQ-014 Port sample_o, output, num_bits_output, signed: head of the output buffer.
REQ-015 Port valid_o, output, 1: sample_o is valid.
REQ-016 Port ready_i, input, 1: downstream accepts sample_o.
REQ-017 Port overflow_o, output, 1: sticky sample-drop flag.
REQ-018 Port state_o, output, 2: current state (IDLE=0, FLUSH=1, SETTLE=2, RUN=3).

Function
REQ-019 FSM states: IDLE, FLUSH, SETTLE, RUN; all outputs are registered or decoded from registered state only.
REQ-020 Transition priority each cycle: enable_i=0 -> IDLE first; then cfg accept; then normal progression.
REQ-021 cfg_ready_o is 1 in IDLE and RUN, and 0 in FLUSH and SETTLE.
REQ-022 Cfg accept = cfg_valid_i & cfg_ready_o; it latches cfg_div_i into div_reg, with value 0 stored as 1.
REQ-023 Cfg accept clears overflow_o and empties the buffer.
REQ-024 IDLE -> FLUSH when enable_i=1; a cfg accept in the same cycle latches the new div first.
REQ-025 RUN with cfg accept and enable_i=1 -> FLUSH.
REQ-026 FLUSH: cic_rst_o=1 and tick_o=0 for exactly 2 cycles, then SETTLE.
REQ-027 cic_rst_o is 0 in every other state.
REQ-028 Tick counter resets to 0 on SETTLE entry and counts 0..div_reg-1, wrapping.
REQ-029 tick_o=1 when the counter equals div_reg-1 and the state is SETTLE or RUN: first pulse div_reg cycles after SETTLE entry, one-cycle pulses, period div_reg; div_reg=1 gives a constant tick.
REQ-030 SETTLE: count tick_dec_i pulses; the first num_of_stages samples are discarded.
REQ-031 SETTLE -> RUN on the cycle the num_of_stages-th tick_dec_i is seen.
REQ-032 The tick counter continues across SETTLE->RUN without restart.
REQ-033 RUN: each tick_dec_i pushes sample_i into a 2-entry FIFO; valid_o rises the cycle after the push (latency 1).
REQ-034 Pop on valid_o & ready_i; sample_o is the oldest entry; order is preserved.
REQ-035 Push while full without a same-cycle pop: the new sample is dropped, old entries are kept, and overflow_o is set next cycle.
REQ-036 Push while full with a same-cycle pop: the push is accepted and there is no overflow.
REQ-037 Push and pop when the buffer is empty: not applicable, since valid_o=0.
REQ-038 tick_dec_i in IDLE or FLUSH is ignored.
REQ-039 Leaving RUN (to IDLE or FLUSH) empties the FIFO; valid_o=0 from the next cycle.
REQ-040 overflow_o is cleared only by reset or a cfg accept.

Reset
REQ-041 On rst_i=1 at a clock edge, the block enters IDLE with div_reg=1 and counters=0.
REQ-042 Reset values: tick_o=0, cic_rst_o=0, valid_o=0, sample_o=0, overflow_o=0, state_o=0, cfg_ready_o=1.
REQ-043 Reset overrides all inputs and applies identically mid-operation.

Verification
REQ-044 Reset with num_of_stages=4 -> all outputs at REQ-042 values; cfg_ready_o=1; state_o=0.
REQ-045 Cfg div=3 accepted in IDLE plus enable_i=1 -> cic_rst_o high for 2 cycles; tick_o at SETTLE cycles 2, 5, 8, ...; tick_dec_i samples 1-4 dropped; sample 5 presented with valid_o one cycle after its tick_dec_i.
REQ-046 RUN with ready_i=0 and samples 0x0011, 0x0022, 0x0033 -> 0x0033 dropped and overflow_o=1; then ready_i=1 -> 0x0011 then 0x0022, then valid_o=0.
REQ-047 FIFO full plus tick_dec_i and ready_i=1 in the same cycle -> head popped, new sample stored, overflow_o stays 0.
REQ-048 Cfg div=0 accepted in RUN -> FLUSH for 2 cycles; FIFO cleared; overflow_o cleared; tick_o constant 1 in SETTLE and RUN.
REQ-049 enable_i=0 mid-SETTLE and rst_i=1 mid-RUN -> IDLE next cycle; tick_o=0; valid_o=0; no further output samples.

Source files
------------

// File: rtl/cic_dec_ctrl.sv
// Control wrapper for a CIC decimator: input-rate tick generation, flush/settle
// sequencing after configuration, and a 2-entry output buffer with drop detection.
module cic_dec_ctrl #(
    parameter int num_of_stages   = 4,
    parameter int num_bits_output = 16,
    parameter int div_width       = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic        [div_width-1:0]       cfg_div_i,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    output logic                              tick_o,
    output logic                              cic_rst_o,
    input  logic                              tick_dec_i,
    input  logic signed [num_bits_output-1:0] sample_i,
    output logic signed [num_bits_output-1:0] sample_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              overflow_o,
    output logic        [1:0]                 state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    localparam int DEC_W = (num_of_stages < 2) ? 1 : $clog2(num_of_stages);
    localparam logic [div_width-1:0] DIV_ONE  = div_width'(1);
    localparam logic [DEC_W-1:0]     DEC_LAST = DEC_W'(num_of_stages - 1);

    // A zero period would never produce a tick; treat it as "every cycle".
    function automatic logic [div_width-1:0] sanitize_div(input logic [div_width-1:0] d);
        return (d == '0) ? DIV_ONE : d;
    endfunction

    state_t                              state_q, state_d;
    logic                                flush_cnt_q;
    logic        [div_width-1:0]         tick_cnt_q;
    logic        [div_width-1:0]         div_q;
    logic        [DEC_W-1:0]             dec_cnt_q;
    logic signed [num_bits_output-1:0]   mem_q [2];
    logic                                wr_ptr_q;
    logic                                rd_ptr_q;
    logic        [1:0]                   fill_q;
    logic                                overflow_q;

    logic cfg_acc;
    logic counting;
    logic tick_wrap;
    logic push;
    logic pop;
    logic full;
    logic push_ok;
    logic push_drop;

    assign cfg_ready_o = (state_q == S_IDLE) || (state_q == S_RUN);
    assign cfg_acc     = cfg_valid_i & cfg_ready_o;
    assign counting    = (state_q == S_SETTLE) || (state_q == S_RUN);
    assign tick_wrap   = (tick_cnt_q == (div_q - DIV_ONE));

    assign push      = (state_q == S_RUN) && tick_dec_i;
    assign pop       = valid_o && ready_i;
    assign full      = (fill_q == 2'd2);
    assign push_ok   = push && (!full || pop);
    assign push_drop = push && full && !pop;

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = S_IDLE;
        end else if (cfg_acc) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_FLUSH;
                S_FLUSH:  if (flush_cnt_q) state_d = S_SETTLE;
                S_SETTLE: if (tick_dec_i && (dec_cnt_q == DEC_LAST)) state_d = S_RUN;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            flush_cnt_q <= 1'b0;
            tick_cnt_q  <= '0;
            div_q       <= DIV_ONE;
            dec_cnt_q   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fill_q      <= 2'd0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= (state_q == S_FLUSH) ? ~flush_cnt_q : 1'b0;

            if (cfg_acc) div_q <= sanitize_div(cfg_div_i);

            // Counter is held at 0 outside SETTLE/RUN so SETTLE always starts from 0.
            if (counting) tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + 1'b1;
            else          tick_cnt_q <= '0;

            if (state_q != S_SETTLE)  dec_cnt_q <= '0;
            else if (tick_dec_i)      dec_cnt_q <= dec_cnt_q + 1'b1;

            // Anything other than staying in (or entering) RUN empties the buffer.
            if (state_d != S_RUN) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                fill_q   <= 2'd0;
            end else begin
                if (pop)     rd_ptr_q <= ~rd_ptr_q;
                if (push_ok) wr_ptr_q <= ~wr_ptr_q;
                case ({push_ok, pop})
                    2'b10:   fill_q <= fill_q + 2'd1;
                    2'b01:   fill_q <= fill_q - 2'd1;
                    default: fill_q <= fill_q;
                endcase
            end

            if (cfg_acc)                              overflow_q <= 1'b0;
            else if ((state_d == S_RUN) && push_drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_d == S_RUN) && push_ok) mem_q[wr_ptr_q] <= sample_i;
    end

    assign valid_o    = (fill_q != 2'd0);
    assign sample_o   = valid_o ? mem_q[rd_ptr_q] : '0;
    assign tick_o     = counting && tick_wrap;
    assign cic_rst_o  = (state_q == S_FLUSH);
    assign overflow_o = overflow_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl: reset, flush/settle sequencing, tick timing,
// output buffer ordering, overflow, reconfiguration and abort paths.
module tb_cic_dec_ctrl;

    localparam int NS = 4;
    localparam int NB = 16;
    localparam int DW = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 enable_i;
    logic        [DW-1:0] cfg_div_i;
    logic                 cfg_valid_i;
    logic                 cfg_ready_o;
    logic                 tick_o;
    logic                 cic_rst_o;
    logic                 tick_dec_i;
    logic signed [NB-1:0] sample_i;
    logic signed [NB-1:0] sample_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 overflow_o;
    logic        [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    cic_dec_ctrl #(
        .num_of_stages  (NS),
        .num_bits_output(NB),
        .div_width      (DW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .tick_o     (tick_o),
        .cic_rst_o  (cic_rst_o),
        .tick_dec_i (tick_dec_i),
        .sample_i   (sample_i),
        .sample_o   (sample_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [NB-1:0] s);
        tick_dec_i = 1'b1;
        sample_i   = s;
        step();
        tick_dec_i = 1'b0;
        step();
    endtask

    initial begin
        rst_i       = 1'b1;
        enable_i    = 1'b0;
        cfg_div_i   = '0;
        cfg_valid_i = 1'b0;
        tick_dec_i  = 1'b0;
        sample_i    = '0;
        ready_i     = 1'b0;
        step();
        step();

        chk("rst_tick",      32'(tick_o),      0);
        chk("rst_cic_rst",   32'(cic_rst_o),   0);
        chk("rst_valid",     32'(valid_o),     0);
        chk("rst_sample",    32'(sample_o),    0);
        chk("rst_overflow",  32'(overflow_o),  0);
        chk("rst_state",     32'(state_o),     0);
        chk("rst_cfg_ready", 32'(cfg_ready_o), 1);

        // Configure div=3 in IDLE together with enable
        rst_i       = 1'b0;
        cfg_div_i   = 16'd3;
        cfg_valid_i = 1'b1;
        enable_i    = 1'b1;
        step();
        chk("flush1_state",     32'(state_o),     1);
        chk("flush1_cic_rst",   32'(cic_rst_o),   1);
        chk("flush1_tick",      32'(tick_o),      0);
        chk("flush1_cfg_ready", 32'(cfg_ready_o), 0);
        cfg_valid_i = 1'b0;
        cfg_div_i   = '0;
        step();
        chk("flush2_state",   32'(state_o),   1);
        chk("flush2_cic_rst", 32'(cic_rst_o), 1);
        step();
        chk("settle0_state",   32'(state_o),   2);
        chk("settle0_cic_rst", 32'(cic_rst_o), 0);
        chk("settle0_tick",    32'(tick_o),    0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("settle_tick_c%0d", k), 32'(tick_o), ((k % 3) == 2) ? 1 : 0);
        end

        // Four settling samples are discarded
        pulse(16'h0001);
        pulse(16'h0002);
        pulse(16'h0003);
        chk("settle_state_after3", 32'(state_o), 2);
        chk("settle_valid_after3", 32'(valid_o), 0);
        pulse(16'h0004);
        chk("run_state",        32'(state_o), 3);
        chk("run_tick_contin",  32'(tick_o),  1);
        chk("run_valid_dropped", 32'(valid_o), 0);

        tick_dec_i = 1'b1;
        sample_i   = 16'h0055;
        step();
        tick_dec_i = 1'b0;
        chk("s5_valid",  32'(valid_o),  1);
        chk("s5_sample", 32'(sample_o), 32'h0055);
        ready_i = 1'b1;
        step();
        chk("s5_popped_valid",  32'(valid_o),  0);
        chk("s5_popped_sample", 32'(sample_o), 0);
        ready_i = 1'b0;

        // Overflow with downstream stalled
        pulse(16'h0011);
        chk("ov_first_valid",  32'(valid_o),  1);
        chk("ov_first_sample", 32'(sample_o), 32'h0011);
        pulse(16'h0022);
        chk("ov_second_head", 32'(sample_o),   32'h0011);
        chk("ov_second_flag", 32'(overflow_o), 0);
        pulse(16'h0033);
        chk("ov_third_flag", 32'(overflow_o), 1);
        chk("ov_third_head", 32'(sample_o),   32'h0011);
        ready_i = 1'b1;
        step();
        chk("ov_drain1_valid",  32'(valid_o),  1);
        chk("ov_drain1_sample", 32'(sample_o), 32'h0022);
        step();
        chk("ov_drain2_valid", 32'(valid_o),    0);
        chk("ov_sticky",       32'(overflow_o), 1);
        ready_i = 1'b0;

        // Reconfigure to div=0 while running
        pulse(16'h0077);
        chk("recfg_pre_valid",     32'(valid_o),     1);
        chk("recfg_pre_cfg_ready", 32'(cfg_ready_o), 1);
        cfg_div_i   = 16'd0;
        cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        chk("recfg_state",    32'(state_o),    1);
        chk("recfg_valid",    32'(valid_o),    0);
        chk("recfg_overflow", 32'(overflow_o), 0);
        chk("recfg_cic_rst",  32'(cic_rst_o),  1);
        step();
        chk("recfg_flush2_state", 32'(state_o), 1);
        step();
        chk("recfg_settle_state", 32'(state_o), 2);
        chk("recfg_settle_tick0", 32'(tick_o),  1);
        step();
        chk("recfg_settle_tick1", 32'(tick_o), 1);
        pulse(16'h0101);
        pulse(16'h0102);
        pulse(16'h0103);
        pulse(16'h0104);
        chk("recfg_run_state", 32'(state_o), 3);
        chk("recfg_run_tick",  32'(tick_o),  1);
        chk("recfg_run_valid", 32'(valid_o), 0);

        // Push into a full buffer with a simultaneous pop
        pulse(16'h0044);
        pulse(16'h0066);
        chk("fullpop_pre_head", 32'(sample_o), 32'h0044);
        tick_dec_i = 1'b1;
        sample_i   = 16'h0088;
        ready_i    = 1'b1;
        step();
        tick_dec_i = 1'b0;
        chk("fullpop_head",     32'(sample_o),   32'h0066);
        chk("fullpop_valid",    32'(valid_o),    1);
        chk("fullpop_overflow", 32'(overflow_o), 0);
        step();
        chk("fullpop_new_head", 32'(sample_o),   32'h0088);
        chk("fullpop_ov_after", 32'(overflow_o), 0);
        ready_i = 1'b0;

        // Reset mid-RUN
        rst_i = 1'b1;
        step();
        chk("midrst_state",  32'(state_o),  0);
        chk("midrst_valid",  32'(valid_o),  0);
        chk("midrst_tick",   32'(tick_o),   0);
        chk("midrst_sample", 32'(sample_o), 0);
        rst_i = 1'b0;
        step();
        chk("midrst_flush_state", 32'(state_o), 1);
        step();
        step();
        chk("midrst_settle_state", 32'(state_o), 2);
        chk("midrst_settle_tick",  32'(tick_o),  1);

        // Disable mid-SETTLE
        enable_i = 1'b0;
        step();
        chk("dis_state",   32'(state_o),   0);
        chk("dis_tick",    32'(tick_o),    0);
        chk("dis_cic_rst", 32'(cic_rst_o), 0);
        pulse(16'h0099);
        chk("dis_ignored_valid", 32'(valid_o), 0);
        chk("dis_ignored_state", 32'(state_o), 0);
        step();
        chk("dis_idle_valid", 32'(valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
